serial_addsub: RTL and testbench

Bit-serial WIDTH-bit adder/subtractor with a valid/ready handshake on both input and output. It is the sequential counterpart of the combinational ripple-carry adder. It reuses a single full-adder slice over WIDTH clock cycles, and it adds subtraction (a − b as a + ~b + 1). It sits in the arithmetic datapath wherever area matters more than latency, and it accepts one operation at a time.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/full_adder.sv | 13 +
 rtl/serial_addsub.sv | 101 ++++++++++
 tb/tb_serial_addsub.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full-adder slice, the same cell a ripple-carry adder chains.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice reused over WIDTH cycles, LSB first.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] res_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry_reg;
  logic             co_reg;
  logic             ovf_reg;
  logic [CW-1:0]    cnt_reg;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters from the MSB side; after the last shift this is the full result.
  assign res_next = {fa_s, res_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      co_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub == OP_SUB}};
            carry_reg <= sub;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_co;
          res_reg   <= res_next[WIDTH-1:1];
          if (cnt_reg == CW'(WIDTH - 1)) begin
            // carry_reg here is the carry into the MSB, fa_co the carry out of it.
            s_reg     <= res_next;
            co_reg    <= fa_co;
            ovf_reg   <= carry_reg ^ fa_co;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign s         = s_reg;
  assign co        = co_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: vector table, corner sequences, exhaustive sweep.
module tb_serial_addsub;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       sub = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] s;
  logic       co;
  logic       ovf;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sub;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];
  vec_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t golden(input logic sb, input logic [3:0] aa, input logic [3:0] bb);
    vec_t       v;
    logic [3:0] bx;
    logic [4:0] r;
    bx = sb ? ~bb : bb;
    r  = {1'b0, aa} + {1'b0, bx} + {4'd0, sb};
    v.sub = sb;
    v.a   = aa;
    v.b   = bb;
    v.s   = r[3:0];
    v.co  = r[4];
    if (sb) v.ovf = (aa[3] != bb[3]) && (r[3] != aa[3]);
    else    v.ovf = (aa[3] == bb[3]) && (r[3] != aa[3]);
    return v;
  endfunction

  // Issue one operation, check latency and result; optionally complete the output handshake.
  task automatic run_op(input vec_t e, input bit release_out);
    int   lat;
    bit   ready_seen;
    vec_t x;
    ready_seen = 0;
    for (int n = 0; n < 20; n++) begin
      if (in_ready) begin
        ready_seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("in_ready_wait", 32'(ready_seen), 32'd1);
    if (!ready_seen) return;
    sub = e.sub; a = e.a; b = e.b; in_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(e);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'(WIDTH));
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    x = sb_q.pop_front();
    if (lat == 0) return;
    check("s", 32'(s), 32'(x.s));
    check("co", 32'(co), 32'(x.co));
    check("ovf", 32'(ovf), 32'(x.ovf));
    $display("[TB] op sub=%0d a=%b b=%b -> s=%b co=%0d ovf=%0d (exp s=%b co=%0d ovf=%0d)",
             x.sub, x.a, x.b, s, co, ovf, x.s, x.co, x.ovf);
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("idle_after_handshake", 32'(in_ready), 32'd1);
      check("out_valid_drop", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    bit   seen_valid;
    vec_t e;

    vecs[0] = '{sub: 1'b0, a: 4'b1001, b: 4'b1000, s: 4'b0001, co: 1'b1, ovf: 1'b1};
    vecs[1] = '{sub: 1'b1, a: 4'b0101, b: 4'b0011, s: 4'b0010, co: 1'b1, ovf: 1'b0};
    vecs[2] = '{sub: 1'b1, a: 4'b0011, b: 4'b0101, s: 4'b1110, co: 1'b0, ovf: 1'b0};
    vecs[3] = '{sub: 1'b1, a: 4'b1000, b: 4'b0001, s: 4'b0111, co: 1'b1, ovf: 1'b1};
    vecs[4] = '{sub: 1'b0, a: 4'b0111, b: 4'b0001, s: 4'b1000, co: 1'b0, ovf: 1'b1};
    vecs[5] = '{sub: 1'b0, a: 4'b1111, b: 4'b0001, s: 4'b0000, co: 1'b1, ovf: 1'b0};
    vecs[6] = '{sub: 1'b1, a: 4'b0000, b: 4'b0000, s: 4'b0000, co: 1'b1, ovf: 1'b0};

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_op(vecs[i], 1'b1);

    // Backpressure: result held, new requests ignored while out_ready is low.
    run_op(vecs[0], 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = 4'($urandom);
      b = 4'($urandom);
      sub = 1'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_s", 32'(s), 32'(vecs[0].s));
      check("bp_co", 32'(co), 32'(vecs[0].co));
      check("bp_ovf", 32'(ovf), 32'(vecs[0].ovf));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_hold_s_after", 32'(s), 32'(vecs[0].s));

    // Reset during the second SHIFT cycle aborts the operation.
    sub = 1'b0; a = 4'b1111; b = 4'b1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_s", 32'(s), 32'd0);
    check("abort_co", 32'(co), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    check("abort_in_ready_held", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready || s != 4'd0) seen_valid = 1;
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);
    $display("[TB] reset-abort sequence: in_ready=%0d out_valid=%0d s=%b", in_ready, out_valid, s);

    // Exhaustive sweep against the golden model.
    for (int k = 0; k < 512; k++) begin
      e = golden(k[8], k[7:4], k[3:0]);
      run_op(e, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
